// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and word geometry.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream; strobes word_valid on the 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    // Only the three earlier bytes need storing; the 4th arrives alongside word_valid.
    logic [23:0]           shift_q, shift_d;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            idx_d   = idx_q + BYTE_IDX_W'(1);
            shift_d = {shift_q[15:0], byte_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign word       = {shift_q, byte_data};
    assign word_valid = byte_valid && !clear && (idx_q == LAST_IDX);

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed big-endian program image from a byte stream into instruction memory,
// holding the CPU in reset until the whole image has been written.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int MEM_SIZE   = 1450,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  reload,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [31:0]           wd,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] word_count
);

    localparam logic [ADDR_WIDTH-1:0] MEM_SIZE_W = ADDR_WIDTH'(MEM_SIZE);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
    logic [ADDR_WIDTH-1:0] wc_q, wc_d, wa_q, wa_d;
    logic [31:0]           wd_q, wd_d;
    logic                  we_q, we_d, done_q, done_d, error_q, error_d, hold_q, hold_d;

    logic [31:0]           word;
    logic                  word_valid, accepting, oversize;
    logic [ADDR_WIDTH-1:0] hdr_n;

    assign accepting = (state_q == ST_HEADER) || (state_q == ST_LOAD);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (reload),
        .byte_valid (rx_valid && accepting),
        .byte_data  (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Nonzero bits above the address width mean the count cannot fit, so it is oversize too.
    assign hdr_n    = word[ADDR_WIDTH-1:0];
    assign oversize = (|(word >> ADDR_WIDTH)) || (hdr_n > MEM_SIZE_W);
    assign addr_inc = addr_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        done_d  = done_q;
        error_d = error_q;
        hold_d  = hold_q;

        if (reload) begin
            state_d = ST_HEADER;
            addr_d  = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            hold_d  = 1'b1;
        end else begin
            case (state_q)
                ST_HEADER: if (word_valid) begin
                    wc_d = hdr_n;
                    if (oversize) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        hold_d  = 1'b1;
                    end else if (hdr_n == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                        addr_d  = '0;
                    end
                end
                ST_LOAD: if (word_valid) begin
                    we_d   = 1'b1;
                    wa_d   = addr_q;
                    wd_d   = word;
                    addr_d = addr_inc;
                    // Completion lands on the same edge as the last write.
                    if (addr_inc == wc_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HEADER;
            addr_q  <= '0;
            wc_q    <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wc_q    <= wc_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            error_q <= error_d;
            hold_q  <= hold_d;
        end
    end

    assign we         = we_q;
    assign wa         = wa_q;
    assign wd         = wd_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized and directed bench for instruction_loader with a byte-stream reference model and write scoreboard.
module tb_instruction_loader;

    localparam int MEM_SIZE = 1450;
    localparam int AW       = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid, reload;
    logic [7:0]    rx_data;
    logic          we, cpu_hold, done, error;
    logic [AW-1:0] wa, word_count;
    logic [31:0]   wd;

    instruction_loader #(.MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .reload     (reload),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] wa;
        logic [31:0]   wd;
    } wr_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit gaps     = 0;

    // Reference model: mode 0 = awaiting header, 1 = loading, 2 = done, 3 = rejected.
    int            mode;
    logic [7:0]    byte_q[$];
    int unsigned   n_words, next_addr;
    logic          exp_done, exp_err, exp_hold;
    logic [AW-1:0] exp_wc;
    wr_t           wq[$];
    wr_t           e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode      = 0;
        byte_q.delete();
        next_addr = 0;
        n_words   = 0;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_hold  = 1'b1;
        exp_wc    = '0;
        wq.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic rl);
        logic [31:0] val;
        if (rl) begin
            mode      = 0;
            byte_q.delete();
            next_addr = 0;
            exp_done  = 1'b0;
            exp_err   = 1'b0;
            exp_hold  = 1'b1;
            return;
        end
        if (!v || mode >= 2) return;
        byte_q.push_back(d);
        if (byte_q.size() < 4) return;
        val = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
        byte_q.delete();
        if (mode == 0) begin
            exp_wc = val[AW-1:0];
            if (val > 32'(MEM_SIZE)) begin
                mode    = 3;
                exp_err = 1'b1;
            end else if (val == 0) begin
                mode     = 2;
                exp_done = 1'b1;
                exp_hold = 1'b0;
            end else begin
                mode      = 1;
                n_words   = val;
                next_addr = 0;
            end
        end else begin
            wq.push_back('{wa: AW'(next_addr), wd: val});
            next_addr++;
            if (next_addr == n_words) begin
                mode     = 2;
                exp_done = 1'b1;
                exp_hold = 1'b0;
            end
        end
    endtask

    // Inputs change just after a rising edge; the model advances on the edge that samples them.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rl);
        rx_valid = v;
        rx_data  = d;
        reload   = rl;
        @(posedge clk);
        model_step(v, d, rl);
        #1;
        rx_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            if (gaps && ($urandom % 3 == 0)) idle(1);
            if (gaps && ($urandom % 40 == 0)) cycle(1'($urandom), 8'($urandom), 1'b1);
            cycle(1'b1, w[31-8*i -: 8], 1'b0);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        check("we", {31'b0, we}, {31'b0, wq.size() != 0});
        if (wq.size() != 0) begin
            e = wq.pop_front();
            if (we) begin
                check("wa", {16'b0, wa}, {16'b0, e.wa});
                check("wd", wd, e.wd);
            end
        end
        check("done", {31'b0, done}, {31'b0, exp_done});
        check("error", {31'b0, error}, {31'b0, exp_err});
        check("cpu_hold", {31'b0, cpu_hold}, {31'b0, exp_hold});
        check("word_count", {16'b0, word_count}, {16'b0, exp_wc});
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL timeout: bench did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal load with idle cycles between bytes
        send_word(32'h0000_0002);
        idle(2);
        send_word(32'h2008_0005);
        idle(1);
        send_word(32'h0109_5020);
        check("norm_wc", {16'b0, word_count}, 32'd2);
        check("norm_done", {31'b0, done}, 32'd1);
        check("norm_hold", {31'b0, cpu_hold}, 32'd0);
        idle(2);
        cycle(1'b0, 8'h00, 1'b1);

        // Back-to-back bytes
        send_word(32'h0000_0002);
        send_word(32'h2008_0005);
        send_word(32'h0109_5020);
        idle(2);
        cycle(1'b0, 8'h00, 1'b1);

        // Oversize, upper-bit and zero headers
        send_word(32'h0000_05AB);
        send_word(32'h1122_3344);
        check("ovr_err", {31'b0, error}, 32'd1);
        check("ovr_hold", {31'b0, cpu_hold}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        send_word(32'h0001_0000);
        check("upper_err", {31'b0, error}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        send_word(32'h0000_05AA);
        send_word(32'h0000_0000);
        cycle(1'b0, 8'h00, 1'b1);
        send_word(32'h0000_0000);
        check("zero_done", {31'b0, done}, 32'd1);
        send_word(32'hCAFE_F00D);
        idle(1);
        cycle(1'b0, 8'h00, 1'b1);

        // Reload mid-word
        send_word(32'h0000_0003);
        send_word(32'h0102_0304);
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        send_word(32'h0000_0001);
        send_word(32'hDEAD_BEEF);
        check("rl_wc", {16'b0, word_count}, 32'd1);
        check("rl_done", {31'b0, done}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);

        // Async reset between edges during LOAD
        send_word(32'h0000_0003);
        send_word(32'h5555_AAAA);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_we", {31'b0, we}, 32'd0);
        check("arst_wa", {16'b0, wa}, 32'd0);
        check("arst_wd", wd, 32'd0);
        check("arst_hold", {31'b0, cpu_hold}, 32'd1);
        check("arst_wc", {16'b0, word_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h0000_0001);
        send_word(32'h7766_5544);
        cycle(1'b0, 8'h00, 1'b1);

        // Reload and a byte on the same cycle: the byte is dropped
        cycle(1'b1, 8'hFF, 1'b1);
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
        check("coll_done", {31'b0, done}, 32'd1);
        cycle(1'b0, 8'h00, 1'b1);

        // Randomized images with gaps, stray reloads and rejected headers
        gaps = 1;
        for (int t = 0; t < 40; t++) begin
            int          nw;
            logic [31:0] hdr;
            if ($urandom % 6 == 0) begin
                nw  = 0;
                hdr = ($urandom % 2 != 0) ? 32'(MEM_SIZE + 1 + $urandom_range(0, 99))
                                          : ($urandom | 32'h0001_0000);
            end else begin
                nw  = $urandom_range(0, 5);
                hdr = 32'(nw);
            end
            send_word(hdr);
            for (int k = 0; k < nw; k++) send_word($urandom);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) cycle(1'b1, 8'($urandom), 1'b0);
            idle(int'($urandom_range(0, 2)));
            cycle(1'b0, 8'h00, 1'b1);
        end

        idle(3);
        check("sb_empty", wq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Write-side companion to the instruction memory: receives a byte stream, typically from the UART receiver, and writes complete 32-bit instruction words into the instruction memory write port. It sits between the host link and the memory. It holds the CPU in reset (`cpu_hold`) until a full program image has been stored. The image format is a 4-byte big-endian word count N, followed by N big-endian 32-bit words written to addresses 0..N-1.

## Interface
- `MEM_SIZE`, default 1450: number of words in the instruction memory; N greater than this is rejected.
- `ADDR_WIDTH`, default 16: width of the word address.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`  in  8  received byte.
- `reload`  in  1  one-cycle pulse; abandons current state and waits for a new header.
- `we`  out  1  instruction memory write enable, one cycle per word.
- `wa`  out  ADDR_WIDTH  word address for `wd`.
- `wd`  out  32  instruction word.
- `cpu_hold`  out  1  high while no valid image is loaded; drives CPU reset.
- `done`  out  1  image completely written.
- `error`  out  1  header rejected (N > MEM_SIZE); sticky.
- `word_count`  out  ADDR_WIDTH  N latched from the header.

## Operation
- States:
  - HEADER: collecting the 4 count bytes.
  - LOAD: collecting word bytes.
  - DONE
  - ERROR
- Reset state is HEADER. Outputs at reset:
  - `we`=0, `wa`=0, `wd`=0
  - `cpu_hold`=1, `done`=0, `error`=0, `word_count`=0
  - byte index=0, shift register=0, address counter=0
- Byte assembly:
  - 2-bit byte index; each accepted byte shifts in as `shift <= {shift[23:0], rx_data}`.
  - The index wraps from 3 to 0.
  - The first byte received is the MSB.
- HEADER, on the 4th byte:
  - Latch N = low ADDR_WIDTH bits of the assembled value. Bits above ADDR_WIDTH must be zero; otherwise the header is treated as N > MEM_SIZE.
  - If N > MEM_SIZE, go to ERROR.
  - If N = 0, go to DONE.
  - Otherwise, go to LOAD with the address counter at 0.
- LOAD, on the 4th byte of a word:
  - Register `wd` = assembled word, `wa` = address counter, and pulse `we` for one cycle.
  - Increment the address counter.
  - When the counter reaches N, go to DONE.
- DONE:
  - `done`=1, `cpu_hold`=0.
  - `rx_valid` is ignored.
  - `we` never asserts.
- ERROR:
  - `error`=1, `cpu_hold`=1.
  - `rx_valid` is ignored.
- `reload`, in any state:
  - Go to HEADER.
  - Clear the byte index, address counter, `done` and `error`.
  - Set `cpu_hold`=1.
  - Memory contents are not cleared.
- Simultaneous `reload` and `rx_valid`: `reload` wins and the byte is dropped.
- Reset mid-word: the partial word is discarded and nothing is written.

## Timing
- `rx_valid` may assert on consecutive cycles; the block accepts one byte per cycle with no backpressure.
- Write latency: `we`, `wa` and `wd` are registered and valid the cycle after the 4th byte's `rx_valid` edge.
- State transitions:
  - The transition to DONE takes effect on the same edge that raises the last `we`.
  - `done` and the `cpu_hold` fall are visible together with that last write.
  - The memory therefore holds the last word at the next edge, before the CPU leaves reset one cycle later.
- A header with N = 0 raises `done` one cycle after its 4th byte.
- The address counter is ADDR_WIDTH bits. It never wraps, because N ≤ MEM_SIZE < 2^ADDR_WIDTH is enforced at the header.

## Structure
- Shared package (`loader_pkg`) holds:
  - the state encoding (HEADER/LOAD/DONE/ERROR, 2 bits);
  - `BYTES_PER_WORD` = 4.
- One natural sub-module, `byte_packer`:
  - contains the shift register and byte index, with a `word_valid` strobe output;
  - clear input driven by `reload`;
  - reused for both header and word assembly.
- Top-level FSM and address counter stay in `instruction_loader`.

## Test plan
- **Normal load.** Send header 00 00 00 02, then words 20 08 00 05 and 01 09 50 20.
  - Expected writes: `we` at `wa`=0 with `wd`=20080005, then at `wa`=1 with `wd`=01095020.
  - `done`=1 and `cpu_hold`=0 together with the second write.
  - `word_count`=2.
- **Back-to-back bytes.** Send all 12 bytes above on consecutive cycles.
  - Exactly two `we` pulses, 4 cycles apart, with identical data.
- **Oversize and zero headers.**
  - Header 00 00 05 AB (1451): `error`=1, `cpu_hold`=1, no `we`; subsequent bytes ignored.
  - Header 00 01 00 00: `error`=1.
  - Header 00 00 00 00: `done`=1 one cycle later, with no `we`.
- **Reload mid-word.** Send N=3 and one word, then 2 bytes, then `reload`, then a new N=1 header and word DE AD BE EF.
  - Single write at `wa`=0 with `wd`=DEADBEEF.
  - `done`=1 and `word_count`=1.
- **Async reset.** Deassert `rst_n` between clock edges during LOAD.
  - All outputs take their reset values immediately.
  - After release, a fresh header is required.
- **Edge collision.** Assert `reload` and `rx_valid` on the same cycle.
  - The byte is dropped; verify the following 4 bytes form the header.
